// File: rtl/seq_matmul_mkn.sv
// Sequential fixed-point matrix multiplier: Z = A(MxK) * B(KxN) [+ C].
// Operands come from external synchronous RAMs; results stream out row-major over z_stb/z_ack.
module seq_matmul_mkn #(
  parameter int M  = 4,
  parameter int K  = 4,
  parameter int N  = 4,
  parameter int DW = 16,
  parameter int AW = 32,
  localparam int MW = (M > 1) ? $clog2(M) : 1,
  localparam int KW = (K > 1) ? $clog2(K) : 1,
  localparam int NW = (N > 1) ? $clog2(N) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 acc_mode,
  output logic [MW-1:0]        a_i,
  output logic [KW-1:0]        a_k,
  input  logic signed [DW-1:0] a_data,
  output logic [KW-1:0]        b_k,
  output logic [NW-1:0]        b_j,
  input  logic signed [DW-1:0] b_data,
  input  logic signed [DW-1:0] c_data,
  output logic signed [AW-1:0] z_out,
  output logic [MW-1:0]        z_i,
  output logic [NW-1:0]        z_j,
  output logic                 z_stb,
  input  logic                 z_ack,
  output logic                 busy,
  output logic                 done,
  output logic                 overflow
);

  // Product is formed wide enough to be exact so truncation to AW can be detected.
  localparam int PW = 2 * DW;
  localparam int EW = (PW > AW) ? PW : AW;
  localparam logic [MW-1:0] M_LAST = MW'(M - 1);
  localparam logic [KW-1:0] K_LAST = KW'(K - 1);
  localparam logic [NW-1:0] N_LAST = NW'(N - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_INIT, S_FETCH, S_MAC, S_OUT, S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [MW-1:0]       i_q, i_d;
  logic [KW-1:0]       k_q, k_d;
  logic [NW-1:0]       j_q, j_d;
  logic signed [AW-1:0] acc_q, acc_d;
  logic signed [AW-1:0] z_q, z_d;
  logic                stb_q, stb_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                ovf_q, ovf_d;
  logic                mode_q, mode_d;

  logic signed [EW-1:0] a_ext, b_ext, prod_ext;
  logic signed [AW-1:0] prod_aw, sum;
  logic                 prod_fit, add_ovf;

  assign a_ext    = EW'(a_data);
  assign b_ext    = EW'(b_data);
  assign prod_ext = a_ext * b_ext;
  assign prod_aw  = prod_ext[AW-1:0];
  assign prod_fit = (EW'(prod_aw) == prod_ext);
  assign sum      = acc_q + prod_aw;
  assign add_ovf  = (acc_q[AW-1] == prod_aw[AW-1]) && (sum[AW-1] != acc_q[AW-1]);

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    k_d     = k_q;
    j_d     = j_q;
    acc_d   = acc_q;
    z_d     = z_q;
    stb_d   = stb_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    ovf_d   = ovf_q;
    mode_d  = mode_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          mode_d  = acc_mode;
          i_d     = '0;
          j_d     = '0;
          k_d     = '0;
          ovf_d   = 1'b0;
          busy_d  = 1'b1;
          state_d = S_INIT;
        end
      end
      S_INIT: begin
        acc_d   = mode_q ? AW'(c_data) : '0;
        k_d     = '0;
        state_d = S_FETCH;
      end
      S_FETCH: state_d = S_MAC;
      S_MAC: begin
        acc_d = sum;
        if (add_ovf || !prod_fit) ovf_d = 1'b1;
        if (k_q == K_LAST) begin
          z_d     = sum;
          stb_d   = 1'b1;
          state_d = S_OUT;
        end else begin
          k_d     = k_q + 1'b1;
          state_d = S_FETCH;
        end
      end
      S_OUT: begin
        if (z_ack) begin
          stb_d = 1'b0;
          if (j_q == N_LAST) begin
            j_d = '0;
            // Row index is held on the final element so z_i keeps the last row.
            if (i_q == M_LAST) begin
              state_d = S_DONE;
            end else begin
              i_d     = i_q + 1'b1;
              state_d = S_INIT;
            end
          end else begin
            j_d     = j_q + 1'b1;
            state_d = S_INIT;
          end
        end
      end
      S_DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      i_q     <= '0;
      k_q     <= '0;
      j_q     <= '0;
      acc_q   <= '0;
      z_q     <= '0;
      stb_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      k_q     <= k_d;
      j_q     <= j_d;
      acc_q   <= acc_d;
      z_q     <= z_d;
      stb_q   <= stb_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
      mode_q  <= mode_d;
    end
  end

  assign a_i      = i_q;
  assign a_k      = k_q;
  assign b_k      = k_q;
  assign b_j      = j_q;
  assign z_i      = i_q;
  assign z_j      = j_q;
  assign z_out    = z_q;
  assign z_stb    = stb_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_seq_matmul_mkn.sv
// Directed bench for seq_matmul_mkn: 2x2x2 vector table plus rectangular, overflow and reset sequences.
module tb_seq_matmul_mkn;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- 2x2x2, DW=16, AW=32 ----------------
  logic              s2_start = 0, s2_mode = 0, s2_ack = 0;
  logic [0:0]        s2_ai, s2_ak, s2_bk, s2_bj, s2_zi, s2_zj;
  logic signed [15:0] s2_ad, s2_bd, s2_cd;
  logic signed [31:0] s2_z;
  logic              s2_stb, s2_busy, s2_done, s2_ovf;
  logic signed [15:0] m2_a[4], m2_b[4], m2_c[4];

  always @(posedge clk) begin
    s2_ad <= m2_a[{s2_ai, s2_ak}];
    s2_bd <= m2_b[{s2_bk, s2_bj}];
  end
  assign s2_cd = m2_c[{s2_zi, s2_zj}];

  seq_matmul_mkn #(.M(2), .K(2), .N(2), .DW(16), .AW(32)) dut2 (
    .clk(clk), .rst(rst), .start(s2_start), .acc_mode(s2_mode),
    .a_i(s2_ai), .a_k(s2_ak), .a_data(s2_ad),
    .b_k(s2_bk), .b_j(s2_bj), .b_data(s2_bd), .c_data(s2_cd),
    .z_out(s2_z), .z_i(s2_zi), .z_j(s2_zj), .z_stb(s2_stb), .z_ack(s2_ack),
    .busy(s2_busy), .done(s2_done), .overflow(s2_ovf)
  );

  // ---------------- M=2, K=3, N=1 ----------------
  logic              s3_start = 0, s3_ack = 0;
  logic              s3_mode = 0;
  logic [0:0]        s3_ai, s3_bj, s3_zi, s3_zj;
  logic [1:0]        s3_ak, s3_bk;
  logic signed [15:0] s3_ad, s3_bd;
  logic signed [15:0] s3_cd = '0;
  logic signed [31:0] s3_z;
  logic              s3_stb, s3_busy, s3_done, s3_ovf;
  logic signed [15:0] m3_a[6], m3_b[3];

  always @(posedge clk) begin
    s3_ad <= m3_a[int'(s3_ai) * 3 + int'(s3_ak)];
    s3_bd <= m3_b[int'(s3_bk)];
  end

  seq_matmul_mkn #(.M(2), .K(3), .N(1), .DW(16), .AW(32)) dut3 (
    .clk(clk), .rst(rst), .start(s3_start), .acc_mode(s3_mode),
    .a_i(s3_ai), .a_k(s3_ak), .a_data(s3_ad),
    .b_k(s3_bk), .b_j(s3_bj), .b_data(s3_bd), .c_data(s3_cd),
    .z_out(s3_z), .z_i(s3_zi), .z_j(s3_zj), .z_stb(s3_stb), .z_ack(s3_ack),
    .busy(s3_busy), .done(s3_done), .overflow(s3_ovf)
  );

  // ---------------- M=N=1, K=4, DW=8, AW=16 ----------------
  logic              s1_start = 0, s1_ack = 0;
  logic              s1_mode = 0;
  logic [0:0]        s1_ai, s1_bj, s1_zi, s1_zj;
  logic [1:0]        s1_ak, s1_bk;
  logic signed [7:0] s1_ad, s1_bd;
  logic signed [7:0] s1_cd = '0;
  logic signed [15:0] s1_z;
  logic              s1_stb, s1_busy, s1_done, s1_ovf;
  logic signed [7:0] m1_a[4], m1_b[4];

  always @(posedge clk) begin
    s1_ad <= m1_a[s1_ak];
    s1_bd <= m1_b[s1_bk];
  end

  seq_matmul_mkn #(.M(1), .K(4), .N(1), .DW(8), .AW(16)) dut1 (
    .clk(clk), .rst(rst), .start(s1_start), .acc_mode(s1_mode),
    .a_i(s1_ai), .a_k(s1_ak), .a_data(s1_ad),
    .b_k(s1_bk), .b_j(s1_bj), .b_data(s1_bd), .c_data(s1_cd),
    .z_out(s1_z), .z_i(s1_zi), .z_j(s1_zj), .z_stb(s1_stb), .z_ack(s1_ack),
    .busy(s1_busy), .done(s1_done), .overflow(s1_ovf)
  );

  // Element e of each packed array is row-major index row*2+col.
  typedef struct packed {
    logic              mode;
    logic [3:0][15:0]  a;
    logic [3:0][15:0]  b;
    logic [3:0][15:0]  c;
    logic [3:0][31:0]  z;
    logic [3:0]        dly;
  } vec_t;

  vec_t vecs[4];

  task automatic load2(input int v);
    for (int e = 0; e < 4; e++) begin
      m2_a[e] = vecs[v].a[e];
      m2_b[e] = vecs[v].b[e];
      m2_c[e] = vecs[v].c[e];
    end
  endtask

  task automatic run2(input int v);
    int n_cyc, elems, hold, end_cyc, dly;
    longint zr, zir, zjr;
    bit fin;
    dly = int'(vecs[v].dly);
    load2(v);
    @(negedge clk);
    s2_mode  = vecs[v].mode;
    s2_start = 1'b1;
    s2_ack   = (dly == 0);
    @(negedge clk);
    s2_start = 1'b0;
    n_cyc = 1; elems = 0; hold = 0; end_cyc = 0; fin = 0;
    zr = 0; zir = 0; zjr = 0;
    check($sformatf("v%0d busy_after_start", v), s2_busy, 1);
    while (!fin && n_cyc < 1000) begin
      if (s2_done) begin
        fin = 1;
        check($sformatf("v%0d elem_count", v), elems, 4);
        check($sformatf("v%0d done_after_last_ack", v), n_cyc, end_cyc + 1);
        check($sformatf("v%0d busy_at_done", v), s2_busy, 0);
        check($sformatf("v%0d overflow", v), s2_ovf, 0);
        if (dly == 0) check($sformatf("v%0d total_cycles", v), n_cyc, 26);
      end else if (s2_stb) begin
        if (hold == 0) begin
          check($sformatf("v%0d elem_in_range", v), elems < 4, 1);
          if (elems < 4) begin
            check($sformatf("v%0d z[%0d]", v, elems), s2_z, $signed(vecs[v].z[elems]));
            check($sformatf("v%0d z_i[%0d]", v, elems), s2_zi, elems / 2);
            check($sformatf("v%0d z_j[%0d]", v, elems), s2_zj, elems % 2);
          end
          if (elems == 0) check($sformatf("v%0d first_latency", v), n_cyc, 6);
          zr = s2_z; zir = s2_zi; zjr = s2_zj;
        end else begin
          check($sformatf("v%0d hold_z", v), s2_z, zr);
          check($sformatf("v%0d hold_zi", v), s2_zi, zir);
          check($sformatf("v%0d hold_zj", v), s2_zj, zjr);
        end
        hold++;
        s2_ack   = (hold > dly);
        s2_start = (dly > 0 && hold == 2);
      end else if (hold > 0) begin
        check($sformatf("v%0d stb_cycles", v), hold, dly + 1);
        elems++;
        end_cyc = n_cyc;
        hold = 0;
        s2_ack = (dly == 0);
        s2_start = 1'b0;
      end
      if (!fin) begin
        @(negedge clk);
        n_cyc++;
      end
    end
    if (!fin) check($sformatf("v%0d run_timeout", v), 0, 1);
    s2_ack = 1'b0;
    s2_start = 1'b0;
    $display("vector %0d mode=%0d dly=%0d elems=%0d cycles=%0d", v, vecs[v].mode, dly, elems, n_cyc);
  endtask

  initial begin
    int e3, n, seen;
    bit fin;
    longint exp3[2];

    vecs[0].mode = 1'b0;
    vecs[0].a    = {16'd4, 16'd3, 16'd2, 16'd1};
    vecs[0].b    = {16'd8, 16'd7, 16'd6, 16'd5};
    vecs[0].c    = '0;
    vecs[0].z    = {32'd50, 32'd43, 32'd22, 32'd19};
    vecs[0].dly  = 4'd0;

    vecs[1].mode = 1'b1;
    vecs[1].a    = {16'd4, 16'd3, 16'd2, 16'd1};
    vecs[1].b    = {16'd8, 16'd7, 16'd6, 16'd5};
    vecs[1].c    = {16'd1, 16'd0, 16'hFF9C, 16'd100};
    vecs[1].z    = {32'd51, 32'd43, 32'hFFFFFFB2, 32'd119};
    vecs[1].dly  = 4'd0;

    vecs[2]      = vecs[0];
    vecs[2].dly  = 4'd5;

    // A=[[-1,0],[2,-3]], B=[[4,-5],[6,7]] -> [[-4,5],[-10,-31]]
    vecs[3].mode = 1'b0;
    vecs[3].a    = {16'hFFFD, 16'd2, 16'd0, 16'hFFFF};
    vecs[3].b    = {16'd7, 16'd6, 16'hFFFB, 16'd4};
    vecs[3].c    = {16'd9, 16'd9, 16'd9, 16'd9};
    vecs[3].z    = {32'hFFFFFFE1, 32'hFFFFFFF6, 32'd5, 32'hFFFFFFFC};
    vecs[3].dly  = 4'd0;

    for (int e = 0; e < 4; e++) begin
      m2_a[e] = '0; m2_b[e] = '0; m2_c[e] = '0;
      m1_a[e] = 8'sd127; m1_b[e] = 8'sd127;
    end
    m3_a[0] = 16'sd1;  m3_a[1] = -16'sd2; m3_a[2] = 16'sd3;
    m3_a[3] = -16'sd4; m3_a[4] = 16'sd5;  m3_a[5] = -16'sd6;
    m3_b[0] = 16'sd7;  m3_b[1] = 16'sd8;  m3_b[2] = 16'sd9;
    exp3[0] = 18; exp3[1] = -42;

    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset z_out", s2_z, 0);
    check("reset z_stb", s2_stb, 0);
    check("reset busy", s2_busy, 0);
    check("reset done", s2_done, 0);
    check("reset overflow", s2_ovf, 0);
    check("reset z_i", s2_zi, 0);
    check("reset z_j", s2_zj, 0);
    check("reset a_k", s2_ak, 0);
    check("reset dut1 z_out", s1_z, 0);
    check("reset dut3 busy", s3_busy, 0);

    for (int v = 0; v < 4; v++) run2(v);

    // Rectangular signed 2x3 * 3x1.
    s3_ack = 1'b1;
    s3_start = 1'b1;
    @(negedge clk);
    s3_start = 1'b0;
    n = 1; e3 = 0; fin = 0;
    while (!fin && n < 500) begin
      if (s3_done) begin
        fin = 1;
        check("rect elem_count", e3, 2);
        check("rect overflow", s3_ovf, 0);
      end else if (s3_stb) begin
        check("rect elem_in_range", e3 < 2, 1);
        if (e3 < 2) begin
          check($sformatf("rect z[%0d]", e3), s3_z, exp3[e3]);
          check($sformatf("rect z_i[%0d]", e3), s3_zi, e3);
          check($sformatf("rect z_j[%0d]", e3), s3_zj, 0);
        end
        if (e3 == 0) check("rect first_latency", n, 8);
        e3++;
      end
      if (!fin) begin
        @(negedge clk);
        n++;
      end
    end
    if (!fin) check("rect run_timeout", 0, 1);
    s3_ack = 1'b0;
    $display("rect run elems=%0d cycles=%0d", e3, n);

    // Overflow: four 127*127 products wrap a 16-bit accumulator.
    s1_ack = 1'b1;
    s1_start = 1'b1;
    @(negedge clk);
    s1_start = 1'b0;
    n = 1; seen = 0; fin = 0;
    while (!fin && n < 500) begin
      if (s1_done) begin
        fin = 1;
        check("ovf elem_count", seen, 1);
        check("ovf sticky", s1_ovf, 1);
      end else if (s1_stb) begin
        check("ovf z_out", s1_z, -1020);
        check("ovf flag", s1_ovf, 1);
        seen++;
      end
      if (!fin) begin
        @(negedge clk);
        n++;
      end
    end
    if (!fin) check("ovf run_timeout", 0, 1);
    $display("overflow run z=%0d ovf=%0d", s1_z, s1_ovf);
    for (int e = 0; e < 4; e++) m1_b[e] = '0;
    s1_start = 1'b1;
    @(negedge clk);
    s1_start = 1'b0;
    check("ovf cleared_by_start", s1_ovf, 0);
    n = 1; fin = 0;
    while (!fin && n < 500) begin
      if (s1_stb) begin
        fin = 1;
        check("ovf rerun z_out", s1_z, 0);
        check("ovf rerun flag", s1_ovf, 0);
      end else begin
        @(negedge clk);
        n++;
      end
    end
    if (!fin) check("ovf rerun_timeout", 0, 1);
    repeat (4) @(negedge clk);
    s1_ack = 1'b0;
    $display("overflow rerun z=%0d ovf=%0d", s1_z, s1_ovf);

    // Reset while element (1,0) is in its first MAC cycle.
    load2(0);
    s2_mode = 1'b0;
    s2_ack = 1'b1;
    s2_start = 1'b1;
    @(negedge clk);
    s2_start = 1'b0;
    n = 1; seen = 0; e3 = 0;
    while (seen < 2 && n < 500) begin
      @(negedge clk);
      n++;
      if (s2_stb) e3 = 1;
      else if (e3 == 1) begin
        seen++;
        e3 = 0;
      end
    end
    check("rstmid reached_elem2", seen, 2);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rstmid z_out", s2_z, 0);
    check("rstmid z_stb", s2_stb, 0);
    check("rstmid busy", s2_busy, 0);
    check("rstmid done", s2_done, 0);
    check("rstmid z_i", s2_zi, 0);
    check("rstmid z_j", s2_zj, 0);
    seen = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (s2_stb || s2_done) seen++;
    end
    check("rstmid quiet_after_reset", seen, 0);
    s2_ack = 1'b0;
    $display("reset mid-run applied at cycle %0d", n + 2);
    run2(0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
